// File: rtl/posit_extract_pkg.sv
// posit_defines: shared constants and the serialized value record used by the
// posit decoder and the arithmetic stages it feeds.
//   NBITS                      posit word width
//   ES                         exponent field width
//   FBITS                      fraction width including the hidden bit
//   POSIT_SERIALIZED_WIDTH_ES2 width of the serialized value bus
//   value_t / pack()           {sgn, scale[7:0], fraction[27:0], inf, zero}
package posit_defines;

  localparam int NBITS = 32;
  localparam int ES    = 2;
  localparam int FBITS = NBITS - ES - 2;
  localparam int POSIT_SERIALIZED_WIDTH_ES2 = 39;

  typedef struct packed {
    logic             sgn;
    logic [7:0]       scale;
    logic [FBITS-1:0] fraction;
    logic             inf;
    logic             zero;
  } value_t;

  function automatic logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] pack(input value_t v);
    return {v.sgn, v.scale, v.fraction, v.inf, v.zero};
  endfunction

endpackage

// File: rtl/posit_regime_count.sv
// posit_regime_count: combinational regime decoder.
//   abs_i  magnitude bits [30:0] of the posit (sign already removed)
//   m_o    regime run length, 1..31 (31 means no terminating bit)
//   rem_o  bits after the terminator, left-aligned, zero-filled
module posit_regime_count (
  input  logic [30:0] abs_i,
  output logic [4:0]  m_o,
  output logic [28:0] rem_o
);

  logic found;

  always_comb begin
    m_o   = 5'd31;
    found = 1'b0;
    for (int i = 29; i >= 0; i--) begin
      if (!found && (abs_i[i] != abs_i[30])) begin
        m_o   = 5'(30 - i);
        found = 1'b1;
      end
    end
  end

  // With m=1 the remainder is exactly abs[28:0]; each extra regime bit
  // shifts it one place further left. Large m shifts everything out.
  assign rem_o = abs_i[28:0] << (m_o - 5'd1);

endmodule

// File: rtl/posit_extract.sv
// posit_extract: two-stage pipelined decoder from a 32-bit posit (es=2) to the
// serialized value format {sgn, scale, fraction, inf, zero}.
//   clk, reset          clock and asynchronous active-high reset
//   in_data/valid/ready input word handshake
//   out_data/valid/ready serialized output handshake, full backpressure
// Optional build macro POSIT_EXTRACT_STATS_EN adds saturating transfer
// counters stat_total, stat_zero, stat_inf as output ports.
import posit_defines::*;

module posit_extract (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NBITS-1:0]                      in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_data,
  output logic                                  out_valid,
  input  logic                                  out_ready
`ifdef POSIT_EXTRACT_STATS_EN
  ,
  output logic [31:0]                           stat_total,
  output logic [31:0]                           stat_zero,
  output logic [31:0]                           stat_inf
`endif
);

  logic        advance;
  logic        s1_load;

  logic        s1_valid_q;
  logic        s1_sgn_q,  s1_sgn_d;
  logic        s1_zero_q, s1_zero_d;
  logic        s1_inf_q,  s1_inf_d;
  logic [30:0] s1_abs_q,  s1_abs_d;

  logic        out_valid_q;
  logic [POSIT_SERIALIZED_WIDTH_ES2-1:0] out_data_q, out_data_d;

  logic [4:0]  m;
  logic [28:0] rem;
  logic [7:0]  k8;
  value_t      v;

  assign advance  = ~out_valid_q | out_ready;
  assign s1_load  = ~s1_valid_q | advance;
  assign in_ready = s1_load;

  // Only the low 31 bits of the magnitude are kept: bit 31 is set solely
  // for the inf pattern, which is flagged separately.
  always_comb begin
    s1_sgn_d  = in_data[31];
    s1_zero_d = (in_data == 32'h0000_0000);
    s1_inf_d  = (in_data == 32'h8000_0000);
    s1_abs_d  = in_data[31] ? (~in_data[30:0] + 31'd1) : in_data[30:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_abs_q   <= '0;
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sgn_q  <= s1_sgn_d;
        s1_zero_q <= s1_zero_d;
        s1_inf_q  <= s1_inf_d;
        s1_abs_q  <= s1_abs_d;
      end
    end
  end

  posit_regime_count u_regime (
    .abs_i (s1_abs_q),
    .m_o   (m),
    .rem_o (rem)
  );

  always_comb begin
    k8 = s1_abs_q[30] ? ({3'b000, m} - 8'd1) : (8'd0 - {3'b000, m});
    v  = '0;
    if (s1_inf_q) begin
      v.inf = 1'b1;
    end else if (s1_zero_q) begin
      v.zero = 1'b1;
    end else begin
      v.sgn      = s1_sgn_q;
      v.scale    = {k8[5:0], 2'b00} + {6'b000000, rem[28:27]};
      v.fraction = {1'b1, rem[26:0]};
    end
    out_data_d = pack(v);
  end

  // out_data only changes when a new word moves in, so it holds while
  // stalled and keeps its last value once the pipe drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (advance) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= out_data_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef POSIT_EXTRACT_STATS_EN
  logic        out_fire;
  logic [31:0] stat_total_q, stat_zero_q, stat_inf_q;

  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_total_q <= '0;
      stat_zero_q  <= '0;
      stat_inf_q   <= '0;
    end else if (out_fire) begin
      if (stat_total_q != 32'hFFFF_FFFF) stat_total_q <= stat_total_q + 32'd1;
      if (out_data_q[0] && (stat_zero_q != 32'hFFFF_FFFF)) stat_zero_q <= stat_zero_q + 32'd1;
      if (out_data_q[1] && (stat_inf_q != 32'hFFFF_FFFF))  stat_inf_q  <= stat_inf_q + 32'd1;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_zero  = stat_zero_q;
  assign stat_inf   = stat_inf_q;
`endif

endmodule
